// File: rtl/house_visit_tracker.sv
// Tracks NUM_AGENTS walkers driven round-robin by a one-hot move stream and counts distinct
// cells visited in an on-chip bitmap. Define HOUSE_VISIT_TRACKER_WRAP_CHECK_EN for wrap flagging.
module house_visit_tracker #(
  parameter int unsigned NUM_AGENTS   = 1,
  parameter int unsigned COORD_WIDTH  = 8,
  parameter int unsigned RESULT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    shift_valid,
  input  logic [3:0]              shift_direction,
  input  logic                    end_of_file,
  output logic                    shift_ready,
  output logic                    outbound_valid,
  output logic [RESULT_WIDTH-1:0] outbound_data,
  output logic                    overrun,
  output logic                    coord_wrap_error
);

  localparam int unsigned AddrWidth = 2 * COORD_WIDTH;
  localparam int unsigned Depth     = 2 ** AddrWidth;
  localparam int unsigned PtrWidth  = (NUM_AGENTS > 1) ? $clog2(NUM_AGENTS) : 1;

  typedef logic [COORD_WIDTH-1:0]  coord_t;
  typedef logic [RESULT_WIDTH-1:0] count_t;
  typedef logic [AddrWidth-1:0]    addr_t;
  typedef logic [PtrWidth-1:0]     ptr_t;

  localparam coord_t CoordOne = coord_t'(1);
  localparam count_t CountOne = count_t'(1);
  localparam addr_t  AddrOne  = addr_t'(1);
  localparam ptr_t   PtrOne   = ptr_t'(1);
  localparam ptr_t   PtrLast  = ptr_t'(NUM_AGENTS - 1);

  typedef enum logic [2:0] {StClear, StIdle, StLookup, StUpdate, StDone} state_e;

  state_e state_q, state_d;
  addr_t  clr_addr_q, clr_addr_d;
  addr_t  addr_q, addr_d;
  coord_t x_q [NUM_AGENTS];
  coord_t x_d [NUM_AGENTS];
  coord_t y_q [NUM_AGENTS];
  coord_t y_d [NUM_AGENTS];
  ptr_t   ptr_q, ptr_d;
  count_t count_q, count_d;
  count_t out_data_q, out_data_d;
  logic   out_valid_q, out_valid_d;
  logic   eof_pending_q, eof_pending_d;
  logic   overrun_q, overrun_d;

  logic   mem [Depth];
  logic   rdata_q;
  logic   ram_we;
  logic   ram_wdata;
  addr_t  ram_addr;

  coord_t cur_x, cur_y, nx, ny;
  logic   dir_onehot, eof_now;

`ifdef HOUSE_VISIT_TRACKER_WRAP_CHECK_EN
  localparam coord_t CoordMax = {1'b0, {(COORD_WIDTH - 1){1'b1}}};
  localparam coord_t CoordMin = ~CoordMax;
  logic wrap_q, wrap_d, wrap_hit;
`endif

  always_comb begin
    state_d       = state_q;
    clr_addr_d    = clr_addr_q;
    addr_d        = addr_q;
    x_d           = x_q;
    y_d           = y_q;
    ptr_d         = ptr_q;
    count_d       = count_q;
    out_data_d    = out_data_q;
    out_valid_d   = 1'b0;
    eof_pending_d = eof_pending_q;
    overrun_d     = overrun_q;
    ram_we        = 1'b0;
    ram_wdata     = 1'b1;
    ram_addr      = addr_q;

    cur_x = x_q[0];
    cur_y = y_q[0];
    for (int unsigned i = 0; i < NUM_AGENTS; i++) begin
      if (ptr_q == ptr_t'(i)) begin
        cur_x = x_q[i];
        cur_y = y_q[i];
      end
    end

    nx = cur_x;
    ny = cur_y;
    if (shift_direction[2])      nx = cur_x + CoordOne;
    else if (shift_direction[0]) nx = cur_x - CoordOne;
    if (shift_direction[3])      ny = cur_y + CoordOne;
    else if (shift_direction[1]) ny = cur_y - CoordOne;

    dir_onehot = (shift_direction != 4'b0) &&
                 ((shift_direction & (shift_direction - 4'd1)) == 4'b0);

`ifdef HOUSE_VISIT_TRACKER_WRAP_CHECK_EN
    wrap_d   = wrap_q;
    wrap_hit = (shift_direction[2] && cur_x == CoordMax) ||
               (shift_direction[0] && cur_x == CoordMin) ||
               (shift_direction[3] && cur_y == CoordMax) ||
               (shift_direction[1] && cur_y == CoordMin);
`endif

    shift_ready = (state_q == StIdle);
    if (shift_valid && !shift_ready) overrun_d = 1'b1;
    if (end_of_file && state_q != StDone) eof_pending_d = 1'b1;
    eof_now = eof_pending_q || end_of_file;

    unique case (state_q)
      StClear: begin
        ram_we     = 1'b1;
        ram_addr   = clr_addr_q;
        ram_wdata  = (clr_addr_q == '0);
        clr_addr_d = clr_addr_q + AddrOne;
        if (clr_addr_q == '1) begin
          count_d = CountOne;
          if (eof_now) begin
            state_d     = StDone;
            out_valid_d = 1'b1;
            out_data_d  = CountOne;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StIdle: begin
        if (shift_valid && dir_onehot) begin
          for (int unsigned i = 0; i < NUM_AGENTS; i++) begin
            if (ptr_q == ptr_t'(i)) begin
              x_d[i] = nx;
              y_d[i] = ny;
            end
          end
          addr_d  = {nx, ny};
          ptr_d   = (ptr_q == PtrLast) ? '0 : ptr_q + PtrOne;
          state_d = StLookup;
`ifdef HOUSE_VISIT_TRACKER_WRAP_CHECK_EN
          if (wrap_hit) wrap_d = 1'b1;
`endif
        end else if (eof_now) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
          out_data_d  = count_q;
        end
      end
      StLookup: state_d = StUpdate;
      StUpdate: begin
        if (!rdata_q) begin
          ram_we  = 1'b1;
          count_d = (count_q == '1) ? count_q : count_q + CountOne;
        end
        if (eof_now) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
          out_data_d  = count_d;
        end else begin
          state_d = StIdle;
        end
      end
      StDone: ;
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StClear;
      clr_addr_q    <= '0;
      addr_q        <= '0;
      x_q           <= '{default: '0};
      y_q           <= '{default: '0};
      ptr_q         <= '0;
      count_q       <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      eof_pending_q <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef HOUSE_VISIT_TRACKER_WRAP_CHECK_EN
      wrap_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      clr_addr_q    <= clr_addr_d;
      addr_q        <= addr_d;
      x_q           <= x_d;
      y_q           <= y_d;
      ptr_q         <= ptr_d;
      count_q       <= count_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      eof_pending_q <= eof_pending_d;
      overrun_q     <= overrun_d;
`ifdef HOUSE_VISIT_TRACKER_WRAP_CHECK_EN
      wrap_q        <= wrap_d;
`endif
    end
  end

  // Single-port, read-first bitmap; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rdata_q <= mem[ram_addr];
  end

  assign outbound_valid = out_valid_q;
  assign outbound_data  = out_data_q;
  assign overrun        = overrun_q;
`ifdef HOUSE_VISIT_TRACKER_WRAP_CHECK_EN
  assign coord_wrap_error = wrap_q;
`else
  assign coord_wrap_error = 1'b0;
`endif

endmodule

// File: tb/tb_house_visit_tracker.sv
// Scoreboard bench: two trackers (1 and 2 agents) share one random/directed move stream and are
// checked against a cell-set reference model.
module tb_house_visit_tracker;

  localparam int CW   = 4;
  localparam int RW   = 16;
  localparam int D    = 1 << (2 * CW);
  localparam int SPAN = 1 << CW;
  localparam int CMAX = (1 << (CW - 1)) - 1;
  localparam int CMIN = -(1 << (CW - 1));

  localparam logic [3:0] N = 4'b1000, E = 4'b0100, S = 4'b0010, W = 4'b0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, shift_valid, end_of_file;
  logic [3:0]    shift_direction;
  logic          rdy [2];
  logic          ovld [2];
  logic [RW-1:0] od [2];
  logic          ov [2];
  logic          wr [2];

  house_visit_tracker #(.NUM_AGENTS(1), .COORD_WIDTH(CW), .RESULT_WIDTH(RW)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .shift_valid(shift_valid), .shift_direction(shift_direction),
    .end_of_file(end_of_file), .shift_ready(rdy[0]), .outbound_valid(ovld[0]),
    .outbound_data(od[0]), .overrun(ov[0]), .coord_wrap_error(wr[0])
  );

  house_visit_tracker #(.NUM_AGENTS(2), .COORD_WIDTH(CW), .RESULT_WIDTH(RW)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .shift_valid(shift_valid), .shift_direction(shift_direction),
    .end_of_file(end_of_file), .shift_ready(rdy[1]), .outbound_valid(ovld[1]),
    .outbound_data(od[1]), .overrun(ov[1]), .coord_wrap_error(wr[1])
  );

  typedef struct {
    int data;
    bit ovr;
    bit wrap;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_pass = 0;

  // Reference model: timing expressed as remaining clear cycles and busy cycles after a move.
  int clr_left, busy;
  bit done, pend, m_ovr, was_reset;
  bit m_wrap [2];
  int m_out [2];
  int cnt [2];
  int ptr [2];
  int px [2][4];
  int py [2][4];
  bit vis [2][SPAN][SPAN];

  task automatic chk(input string name, input longint act, input longint expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  function automatic bit m_ready();
    return clr_left == 0 && busy == 0 && !done;
  endfunction

  task automatic m_reset();
    clr_left = D; busy = 0; done = 0; pend = 0; m_ovr = 0;
    for (int d = 0; d < 2; d++) begin
      m_wrap[d] = 0; m_out[d] = 0; cnt[d] = 0; ptr[d] = 0;
      for (int a = 0; a < 4; a++) begin px[d][a] = 0; py[d][a] = 0; end
      for (int i = 0; i < SPAN; i++)
        for (int j = 0; j < SPAN; j++) vis[d][i][j] = 0;
    end
  endtask

  task automatic m_finish();
    exp_t e;
    done = 1;
    for (int d = 0; d < 2; d++) begin
      m_out[d] = cnt[d];
      e.data = cnt[d]; e.ovr = m_ovr; e.wrap = m_wrap[d];
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic m_move(input logic [3:0] dir);
    for (int d = 0; d < 2; d++) begin
      int a, nx, ny;
      a  = ptr[d];
      nx = px[d][a] + int'(dir[2]) - int'(dir[0]);
      ny = py[d][a] + int'(dir[3]) - int'(dir[1]);
`ifdef HOUSE_VISIT_TRACKER_WRAP_CHECK_EN
      if (nx > CMAX || nx < CMIN || ny > CMAX || ny < CMIN) m_wrap[d] = 1;
`endif
      if (nx > CMAX) nx -= SPAN;
      if (nx < CMIN) nx += SPAN;
      if (ny > CMAX) ny -= SPAN;
      if (ny < CMIN) ny += SPAN;
      px[d][a] = nx; py[d][a] = ny;
      if (!vis[d][nx - CMIN][ny - CMIN]) begin
        vis[d][nx - CMIN][ny - CMIN] = 1;
        cnt[d]++;
      end
      ptr[d] = (a + 1) % (d + 1);
    end
  endtask

  // One clock cycle: check state left by the previous edge, then drive and model this edge.
  task automatic step(input bit rn, input bit v, input logic [3:0] dir, input bit eof);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("shift_ready%0d", d), rdy[d], m_ready());
      chk($sformatf("overrun%0d", d), ov[d], m_ovr);
      chk($sformatf("wrap%0d", d), wr[d], m_wrap[d]);
      chk($sformatf("outbound_data%0d", d), od[d], m_out[d]);
      if (was_reset) chk($sformatf("reset_valid%0d", d), ovld[d], 0);
    end
    reset_n = rn; shift_valid = v; shift_direction = dir; end_of_file = eof;
    was_reset = !rn;
    if (!rn) begin
      m_reset();
      return;
    end
    if (v && !m_ready()) m_ovr = 1;
    if (eof && !done) pend = 1;
    if (clr_left > 0) begin
      clr_left--;
      if (clr_left == 0) begin
        for (int d = 0; d < 2; d++) begin
          cnt[d] = 1;
          vis[d][-CMIN][-CMIN] = 1;
        end
        if (pend) m_finish();
      end
    end else if (busy > 0) begin
      busy--;
      if (busy == 0 && pend) m_finish();
    end else if (!done) begin
      if (v && $onehot(dir)) begin
        m_move(dir);
        busy = 2;
      end else if (pend) begin
        m_finish();
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 4'b0, 0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < D + 8 && !m_ready(); i++) step(1, 0, 4'b0, 0);
  endtask

  task automatic mv(input logic [3:0] dir, input bit eof);
    wait_ready();
    step(1, 1, dir, eof);
  endtask

  task automatic eof_idle();
    wait_ready();
    step(1, 0, 4'b0, 1);
  endtask

  task automatic do_reset();
    step(0, 0, 4'b0, 0);
    step(0, 1, E, 1);
  endtask

  // Pulses not yet seen after the bounded drain count as failures.
  task automatic drain();
    idle(6);
    chk("pulse_missing0", q0.size(), 0);
    chk("pulse_missing1", q1.size(), 0);
    q0.delete();
    q1.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ovld[0]) begin
      if (q0.size() == 0) begin
        n_checks++;
        $display("FAIL pulse0: unexpected outbound_valid with data %0d, expected none", od[0]);
      end else begin
        e = q0.pop_front();
        chk("pulse_data0", od[0], e.data);
        chk("pulse_ovr0", ov[0], e.ovr);
        chk("pulse_wrap0", wr[0], e.wrap);
      end
    end
    if (ovld[1]) begin
      if (q1.size() == 0) begin
        n_checks++;
        $display("FAIL pulse1: unexpected outbound_valid with data %0d, expected none", od[1]);
      end else begin
        e = q1.pop_front();
        chk("pulse_data1", od[1], e.data);
        chk("pulse_ovr1", ov[1], e.ovr);
        chk("pulse_wrap1", wr[1], e.wrap);
      end
    end
  end

  initial begin
    reset_n = 0; shift_valid = 0; shift_direction = 4'b0; end_of_file = 0;
    repeat (2) @(negedge clk);
    m_reset();
    was_reset = 1;

    // Single move east.
    mv(E, 0); eof_idle(); drain();

    // Square walk.
    do_reset();
    mv(N, 0); mv(E, 0); mv(S, 0); mv(W, 0); eof_idle(); drain();

    // Alternating N,S five times.
    do_reset();
    for (int i = 0; i < 5; i++) begin mv(N, 0); mv(S, 0); end
    eof_idle(); drain();

    // Moves during CLEAR and while busy are dropped and flagged.
    do_reset();
    idle(5); step(1, 1, N, 0); step(1, 1, E, 0);
    mv(E, 0); step(1, 1, N, 0); step(1, 1, W, 0);
    eof_idle(); drain();

    // EOF during CLEAR, then EOF and moves in DONE are ignored.
    do_reset();
    idle(10); step(1, 0, 4'b0, 1);
    idle(D);
    step(1, 1, E, 1); step(1, 1, N, 0); step(1, 0, 4'b0, 1);
    drain();

    // Run east past the positive edge; last move carries EOF.
    do_reset();
    for (int i = 0; i < SPAN / 2 - 1; i++) mv(E, 0);
    mv(E, 1); drain();

    // Invalid direction codes are discarded.
    do_reset();
    mv(4'b0000, 0); step(1, 1, 4'b0110, 0); step(1, 1, 4'b1111, 0); mv(W, 0);
    eof_idle(); drain();

    // Randomised rounds, including occasional mid-run resets.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        bit v, e, rn;
        logic [3:0] dir;
        v   = ($urandom_range(0, 2) == 0);
        dir = ($urandom_range(0, 4) == 0) ? 4'($urandom) : (4'b0001 << $urandom_range(0, 3));
        e   = ($urandom_range(0, 149) == 0);
        rn  = ($urandom_range(0, 599) != 0);
        step(rn, v, dir, e);
      end
      eof_idle();
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
